// File: rtl/bcd_entry_pkg.sv
// Key codes, entry stage encoding and range helper shared by the operand entry block.
package bcd_entry_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    GET_S = 2'd2,
    HOLD  = 2'd3
  } stage_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // True when a two-digit entry fits into a w-bit unsigned register.
  function automatic logic fits(input logic [6:0] value, input int unsigned w);
    return (w >= 7) || (int'(value) < (1 << w));
  endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// Decimal entry accumulator: holds the value being typed (0..99) and its digit count.
module bcd_accumulator
  import bcd_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       digit_en,
  input  logic [3:0] digit,
  output logic [6:0] value,
  output logic [1:0] count
);

  logic [6:0] next_value;

  // value is at most 9 whenever a digit is appended, so the result never exceeds 99
  assign next_value = value * 7'd10 + {3'b000, digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= {3'b000, digit};
      count <= 2'd1;
    end else if (digit_en && count < 2'd2) begin
      value <= next_value;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad operand entry: collects decimal A, B and selector S, committing each on ENTER.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [SEL_W-1:0] S,
  output logic             operands_valid,
  output logic             err,
  output logic [1:0]       stage,
  output logic [6:0]       entry_value
);

  stage_t     state;
  logic [1:0] count;
  logic       key_digit;
  logic       enter_commit;
  logic       value_ok;
  logic       acc_clear;
  logic       acc_load;
  logic       acc_digit;

  assign key_digit    = key_valid && is_digit(key_code);
  assign enter_commit = key_valid && (key_code == KEY_ENTER) && (state != HOLD) && (count != 2'd0);
  assign value_ok     = (state == GET_S) ? fits(entry_value, SEL_W) : fits(entry_value, WIDTH);

  // Any ENTER that is acted on empties the entry, whether it commits or flags a range error.
  assign acc_clear = (key_valid && key_code == KEY_CLEAR) || enter_commit;
  assign acc_load  = key_digit && (state == HOLD);
  assign acc_digit = key_digit && (state != HOLD);

  bcd_accumulator u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .load     (acc_load),
    .digit_en (acc_digit),
    .digit    (key_code),
    .value    (entry_value),
    .count    (count)
  );

  assign stage = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= GET_A;
      A              <= '0;
      B              <= '0;
      S              <= '0;
      err            <= 1'b0;
      operands_valid <= 1'b0;
    end else begin
      operands_valid <= 1'b0;
      if (key_valid && key_code == KEY_CLEAR) begin
        state <= GET_A;
        err   <= 1'b0;
      end else if (key_digit) begin
        err <= 1'b0;
        if (state == HOLD) state <= GET_A;
      end else if (enter_commit) begin
        if (value_ok) begin
          err <= 1'b0;
          case (state)
            GET_A: begin
              A     <= WIDTH'(entry_value);
              state <= GET_B;
            end
            GET_B: begin
              B     <= WIDTH'(entry_value);
              state <= GET_S;
            end
            GET_S: begin
              S              <= SEL_W'(entry_value);
              state          <= HOLD;
              operands_valid <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: directed scenarios plus random key streams against a digit-list model.
module tb_bcd_operand_entry;

  localparam int WIDTH = 4;
  localparam int SEL_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'h0;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SEL_W-1:0] S;
  logic             operands_valid;
  logic             err;
  logic [1:0]       stage;
  logic [6:0]       entry_value;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model state: stage number, typed digits and committed values
  int m_stage = 0;
  int digits[$];
  int m_a = 0, m_b = 0, m_s = 0, m_err = 0, m_ov = 0;

  bcd_operand_entry #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .A              (A),
    .B              (B),
    .S              (S),
    .operands_valid (operands_valid),
    .err            (err),
    .stage          (stage),
    .entry_value    (entry_value)
  );

  always #5 clk = ~clk;

  function automatic int digits_value();
    int v = 0;
    foreach (digits[i]) v = v * 10 + digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_stage = 0;
    digits.delete();
    m_a = 0; m_b = 0; m_s = 0; m_err = 0; m_ov = 0;
  endtask

  task automatic model_key(input int k);
    int v;
    int limit;
    if (k == 11) begin
      m_stage = 0;
      digits.delete();
      m_err = 0;
    end else if (k <= 9) begin
      m_err = 0;
      if (m_stage == 3) begin
        m_stage = 0;
        digits.delete();
        digits.push_back(k);
      end else if (digits.size() < 2) begin
        digits.push_back(k);
      end
    end else if (k == 10 && m_stage != 3 && digits.size() > 0) begin
      v = digits_value();
      limit = (m_stage == 2) ? (1 << SEL_W) - 1 : (1 << WIDTH) - 1;
      if (v <= limit) begin
        if (m_stage == 0) m_a = v;
        else if (m_stage == 1) m_b = v;
        else begin
          m_s = v;
          m_ov = 1;
        end
        m_stage = m_stage + 1;
        m_err = 0;
      end else begin
        m_err = 1;
      end
      digits.delete();
    end
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      m_ov = 0;
      if (key_valid) model_key(int'(key_code));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A", int'(A), m_a);
      chk("B", int'(B), m_b);
      chk("S", int'(S), m_s);
      chk("operands_valid", int'(operands_valid), m_ov);
      chk("err", int'(err), m_err);
      chk("stage", int'(stage), m_stage);
      chk("entry_value", int'(entry_value), digits_value());
    end
  end

  // called at a falling edge; returns at the next falling edge
  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic mid_cycle_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_S", int'(S), 0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_entry", int'(entry_value), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ov", int'(operands_valid), 0);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int code;
    model_reset();
    idle(2);
    chk("reset_stage", int'(stage), 0);
    chk("reset_entry", int'(entry_value), 0);
    chk("reset_A", int'(A), 0);
    chk("reset_ov", int'(operands_valid), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // full A/B/S entry
    press(1); press(2); press(10); press(3); press(10); press(0); press(4); press(10);
    chk("seq_A", int'(A), 12);
    chk("seq_B", int'(B), 3);
    chk("seq_S", int'(S), 4);
    chk("seq_stage", int'(stage), 3);
    chk("seq_ov_high", int'(operands_valid), 1);
    idle(1);
    chk("seq_ov_low", int'(operands_valid), 0);
    press(10);
    chk("hold_enter_stage", int'(stage), 3);

    // leaving HOLD with a digit, then CLEAR
    press(5);
    chk("hold_digit_stage", int'(stage), 0);
    chk("hold_digit_entry", int'(entry_value), 5);
    chk("hold_digit_A", int'(A), 12);
    press(11);
    chk("clear_entry", int'(entry_value), 0);
    chk("clear_B", int'(B), 3);
    chk("clear_S", int'(S), 4);

    // range error on A
    press(1); press(6); press(10);
    chk("errA_err", int'(err), 1);
    chk("errA_stage", int'(stage), 0);
    chk("errA_A", int'(A), 12);
    chk("errA_entry", int'(entry_value), 0);
    press(7);
    chk("errA_clear", int'(err), 0);
    chk("errA_entry7", int'(entry_value), 7);
    press(11);

    // range error on S and third digit ignored
    press(1); press(10); press(2); press(10);
    press(3); press(2); press(10);
    chk("errS_err", int'(err), 1);
    chk("errS_S", int'(S), 4);
    chk("errS_stage", int'(stage), 2);
    press(9); press(9); press(9);
    chk("three_digit_entry", int'(entry_value), 99);
    press(12);
    chk("ignored_key_entry", int'(entry_value), 99);
    press(11);

    // asynchronous reset between edges
    press(1); press(10); press(4);
    mid_cycle_reset();
    @(negedge clk);
    press(10);
    chk("post_rst_stage", int'(stage), 0);
    chk("post_rst_A", int'(A), 0);
    chk("post_rst_entry", int'(entry_value), 0);

    // random key streams
    for (int i = 0; i < 4000; i++) begin
      key_valid = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 99);
      if (r < 60) code = $urandom_range(0, 9);
      else if (r < 85) code = 10;
      else if (r < 90) code = 11;
      else code = $urandom_range(12, 15);
      key_code = 4'(code);
      if ($urandom_range(0, 199) == 0) mid_cycle_reset();
      @(negedge clk);
    end
    key_valid = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_operand_entry.md
BCD_OPERAND_ENTRY -- requirements
Module: bcd_operand_entry

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits.
REQ-002 Parameter SEL_W, default 5, operation-selector width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 key_valid  input  1  key strobe; high for one clk cycle per key press.
REQ-006 key_code  input  4  key code; valid only when key_valid=1.
REQ-007 A  output  WIDTH  committed operand A, registered.
REQ-008 B  output  WIDTH  committed operand B, registered.
REQ-009 S  output  SEL_W  committed operation selector, registered.
REQ-010 operands_valid  output  1  one-cycle pulse after a complete A/B/S set is committed.
REQ-011 err  output  1  range error; sticky until cleared.
REQ-012 stage  output  2  current state encoding: GET_A=0, GET_B=1, GET_S=2, HOLD=3.
REQ-013 entry_value  output  7  decimal value being typed, binary, 0..99.

Function
REQ-014 Key codes SHALL be: 0x0-0x9 digit; 0xA ENTER; 0xB CLEAR; 0xC-0xF ignored with no state change.
REQ-015 Cycles with key_valid=0 SHALL cause no state change; back-to-back key_valid cycles SHALL each be processed.
REQ-016 Digit d in GET_A/GET_B/GET_S: if digit count <2, entry_value <= entry_value*10+d and count increments; a third digit SHALL be ignored.
REQ-017 ENTER with digit count 0 SHALL be ignored.
REQ-018 ENTER in GET_A/GET_B with entry_value <= 2^WIDTH-1 SHALL load A or B, clear entry_value and count, clear err, and advance to GET_B or GET_S.
REQ-019 ENTER in GET_S with entry_value <= 2^SEL_W-1 SHALL load S, clear entry_value and count, clear err, and go to HOLD.
REQ-020 ENTER with an out-of-range value SHALL set err, clear entry_value and count, keep the state, and leave A/B/S unchanged.
REQ-021 operands_valid SHALL be high for exactly the one cycle following the edge that enters HOLD.
REQ-022 Any digit key SHALL clear err.
REQ-023 HOLD: A/B/S stable; ENTER ignored; digit d SHALL go to GET_A with entry_value=d and count=1.
REQ-024 CLEAR in any state SHALL go to GET_A and clear entry_value, count and err; A/B/S keep their values.
REQ-025 All outputs SHALL be registered; a key accepted at edge n SHALL be visible on outputs after edge n.
REQ-026 A/B/S SHALL change only on an accepted ENTER, so the downstream ALU/display path never sees a partial value.

Reset
REQ-027 While rst=1: state GET_A; A, B, S, entry_value, count and err all 0; operands_valid 0.
REQ-028 Reset asserted mid-entry SHALL discard the partial entry immediately, independent of clk.
REQ-029 The first key SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Package bcd_entry_pkg SHALL hold the key-code constants and the state enum typedef.
REQ-031 Sub-module bcd_accumulator SHALL hold entry_value and the digit count, computing value*10+d (7-bit result, max 99) with load/clear controls; the FSM stays in bcd_operand_entry.

Verification
REQ-032 Keys 1,2,ENTER,3,ENTER,0,4,ENTER -> A=12, B=3, S=4, stage=3, operands_valid one cycle high.
REQ-033 In GET_A: keys 1,6,ENTER -> err=1, stage=0, A unchanged, entry_value=0; then 7 -> err=0, entry_value=7.
REQ-034 In GET_S: keys 3,2,ENTER -> err=1, S unchanged; keys 9,9,9 -> entry_value=99 (third digit ignored).
REQ-035 In HOLD with A=12: key 5 -> stage=0, entry_value=5, A still 12; CLEAR -> entry_value=0, B/S unchanged.
REQ-036 rst pulsed between clk edges after keys 1,ENTER,4 -> all outputs 0 before the next edge; ENTER alone then produces no change.
